// File: rtl/dm_port_arbiter_if.sv
// dm_port_arbiter_if: data-memory port bundle shared by the CPU path, the debug master and MEM.
interface dm_port_arbiter_if;
    logic        cpu_dm_req;
    logic        cpu_dm_we;
    logic [31:0] cpu_dm_addr;
    logic [31:0] cpu_dm_din;
    logic [31:0] cpu_dm_dout;
    logic        cpu_stall;
    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_din;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic [31:0] dm_addr;
    logic [31:0] dm_din;
    logic        dm_we;
    logic [31:0] dm_dout;

    modport slave (
        input  cpu_dm_req, cpu_dm_we, cpu_dm_addr, cpu_dm_din,
        input  dbg_req, dbg_we, dbg_addr, dbg_din, dm_dout,
        output cpu_dm_dout, cpu_stall, dbg_ack, dbg_rdata, dm_addr, dm_din, dm_we
    );

    modport master (
        output cpu_dm_req, cpu_dm_we, cpu_dm_addr, cpu_dm_din,
        output dbg_req, dbg_we, dbg_addr, dbg_din, dm_dout,
        input  cpu_dm_dout, cpu_stall, dbg_ack, dbg_rdata, dm_addr, dm_din, dm_we
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: CPU-priority data-memory port arbiter with a debug starvation guard.
// Define DM_ARB_STATS_EN to get a saturating count of CPU stall cycles on stall_cnt.
module dm_port_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    dm_port_arbiter_if.slave bus,
    output logic [15:0]      stall_cnt
);
    typedef enum logic {IDLE, RESP} state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait;
    logic              r_ack;
    logic [31:0]       r_rdata;
    logic              w_grant;
    logic              w_stall;

    // Debug wins when the CPU is idle or it has already lost MAX_WAIT times; never in the ack cycle.
    assign w_grant = !rst && r_state == IDLE && bus.dbg_req &&
                     (!bus.cpu_dm_req || r_wait == WAIT_W'(MAX_WAIT));
    assign w_stall = bus.cpu_dm_req && w_grant;

    assign bus.dm_addr     = w_grant ? bus.dbg_addr : bus.cpu_dm_addr;
    assign bus.dm_din      = w_grant ? bus.dbg_din : bus.cpu_dm_din;
    assign bus.dm_we       = !rst && (w_grant ? bus.dbg_we : bus.cpu_dm_we && bus.cpu_dm_req);
    assign bus.cpu_stall   = w_stall;
    assign bus.cpu_dm_dout = bus.dm_dout;
    assign bus.dbg_ack     = r_ack;
    assign bus.dbg_rdata   = r_rdata;

    // Debug FSM: a grant captures the read data and spends exactly one cycle in RESP acking it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_wait  <= '0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_grant ? RESP : IDLE;
            r_ack   <= w_grant;
            if (w_grant)
                r_rdata <= bus.dm_dout;
            if (!bus.dbg_req || w_grant)
                r_wait <= '0;
            else if (r_state == IDLE && r_wait != WAIT_W'(MAX_WAIT))
                r_wait <= r_wait + 1'b1;
        end
    end

`ifdef DM_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of cycles the CPU spent stalled behind the debug master.
    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (w_stall && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: scoreboard bench for dm_port_arbiter with a reference model and randomized traffic.
module tb_dm_port_arbiter;
    localparam int MAX_WAIT = 4;
`ifdef DM_ARB_STATS_EN
    localparam logic [15:0] EXP_SCNT = 16'd3;
`else
    localparam logic [15:0] EXP_SCNT = 16'd0;
`endif

    typedef struct {
        logic        chk_reg;
        logic        ack;
        logic [31:0] rdata;
        logic [15:0] scnt;
        logic        stall;
        logic        we;
        logic        ld;
        logic [31:0] dout;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] stall_cnt;
    logic [31:0] mem [0:15];
    logic [31:0] ref_mem [0:15];
    exp_t        sb [$];
    exp_t        me;
    int          n_chk = 0;
    int          n_err = 0;

    logic        s_rst, s_cpu_req, s_cpu_we, s_dbg_req, s_dbg_we;
    logic [31:0] s_cpu_addr, s_cpu_din, s_dbg_addr, s_dbg_din;

    logic        m_known = 1'b0;
    logic        m_ack = 1'b0;
    logic        m_stalled = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [15:0] m_scnt = '0;
    int          m_lost = 0;

    dm_port_arbiter_if bus ();

    dm_port_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    // Free-running clock.
    always #5 clk = ~clk;

    assign bus.dm_dout = mem[bus.dm_addr[5:2]];

    // Memory behind the port: combinational read, write on the rising edge.
    always @(posedge clk)
        if (bus.dm_we)
            mem[bus.dm_addr[5:2]] <= bus.dm_din;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        return 32'($urandom_range(0, 15)) << 2;
    endfunction

    // Drive one cycle of stimulus, predict the DUT response from the rules and queue it.
    task automatic step();
        exp_t e;
        logic g;
        @(posedge clk);
        #1;
        rst             = s_rst;
        bus.cpu_dm_req  = s_cpu_req;
        bus.cpu_dm_we   = s_cpu_we;
        bus.cpu_dm_addr = s_cpu_addr;
        bus.cpu_dm_din  = s_cpu_din;
        bus.dbg_req     = s_dbg_req;
        bus.dbg_we      = s_dbg_we;
        bus.dbg_addr    = s_dbg_addr;
        bus.dbg_din     = s_dbg_din;
        g = !s_rst && !m_ack && s_dbg_req && (!s_cpu_req || m_lost >= MAX_WAIT);
        e.chk_reg = m_known;
        e.ack     = m_ack;
        e.rdata   = m_rdata;
        e.scnt    = m_scnt;
        e.stall   = s_cpu_req && g;
        e.we      = !s_rst && (g ? s_dbg_we : s_cpu_req && s_cpu_we);
        e.ld      = !s_rst && s_cpu_req && !g;
        e.dout    = ref_mem[s_cpu_addr[5:2]];
        sb.push_back(e);
        m_stalled = e.stall;
        if (s_rst) begin
            m_ack   = 1'b0;
            m_rdata = '0;
            m_lost  = 0;
            m_scnt  = '0;
            m_known = 1'b1;
        end else begin
            if (g) begin
                m_rdata = ref_mem[s_dbg_addr[5:2]];
                if (s_dbg_we)
                    ref_mem[s_dbg_addr[5:2]] = s_dbg_din;
            end else if (s_cpu_req && s_cpu_we)
                ref_mem[s_cpu_addr[5:2]] = s_cpu_din;
            if (!s_dbg_req || g)
                m_lost = 0;
            else if (!m_ack)
                m_lost++;
`ifdef DM_ARB_STATS_EN
            if (e.stall && m_scnt != 16'hFFFF)
                m_scnt++;
`endif
            m_ack = g;
        end
    endtask

    // Debug access with the CPU idle; stays bounded since the model always grants an idle port.
    task automatic dbg_access(input logic we, input logic [31:0] addr, input logic [31:0] din);
        s_cpu_req = 1'b0;
        s_dbg_req = 1'b1; s_dbg_we = we; s_dbg_addr = addr; s_dbg_din = din;
        for (int i = 0; i < 10; i++) begin
            step();
            if (m_ack) break;
        end
        s_dbg_req = 1'b0;
        step();
    endtask

    // CPU loads every cycle while a debug read waits for its starvation slot.
    task automatic starve();
        s_dbg_req = 1'b1; s_dbg_we = 1'b0; s_dbg_addr = 32'h10;
        for (int i = 0; i < 12; i++) begin
            s_cpu_req = 1'b1; s_cpu_we = 1'b0; s_cpu_addr = rnd_addr();
            step();
            if (m_ack) break;
        end
        s_dbg_req = 1'b0;
        step();
        s_cpu_req = 1'b0;
        step();
    endtask

    // Monitor: compare every DUT-presented output against the queued prediction.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            me = sb.pop_front();
            check("cpu_stall", 32'(bus.cpu_stall), 32'(me.stall));
            check("dm_we", 32'(bus.dm_we), 32'(me.we));
            if (me.ld)
                check("cpu_dm_dout", bus.cpu_dm_dout, me.dout);
            if (me.chk_reg) begin
                check("dbg_ack", 32'(bus.dbg_ack), 32'(me.ack));
                check("dbg_rdata", bus.dbg_rdata, me.rdata);
                check("stall_cnt", 32'(stall_cnt), 32'(me.scnt));
            end
        end
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        s_rst = 1'b1; s_cpu_req = 1'b1; s_cpu_we = 1'b1; s_cpu_addr = 32'h20; s_cpu_din = 32'h55;
        s_dbg_req = 1'b1; s_dbg_we = 1'b1; s_dbg_addr = 32'h10; s_dbg_din = 32'h66;
        step();
        step();
        s_rst = 1'b0; s_cpu_req = 1'b0; s_dbg_req = 1'b0;
        step();
        dbg_access(1'b1, 32'h10, 32'hDEADBEEF);
        dbg_access(1'b0, 32'h10, 32'h0);
        repeat (3) starve();
        step();
        @(negedge clk);
        check("stall_cnt_after_3_starves", 32'(stall_cnt), 32'(EXP_SCNT));
        s_cpu_req = 1'b0; s_dbg_req = 1'b1; s_dbg_we = 1'b0; s_dbg_addr = 32'h10;
        repeat (6) step();
        s_dbg_req = 1'b0;
        step();
        s_dbg_req = 1'b1; s_dbg_we = 1'b0; s_dbg_addr = 32'h20;
        s_cpu_req = 1'b1; s_cpu_we = 1'b0; s_cpu_addr = 32'h00;
        repeat (MAX_WAIT) step();
        s_cpu_we = 1'b1; s_cpu_addr = 32'h20; s_cpu_din = 32'h1;
        step();
        s_dbg_req = 1'b0;
        step();
        s_cpu_req = 1'b0;
        step();
        dbg_access(1'b0, 32'h20, 32'h0);
        for (int c = 0; c < 3000; c++) begin
            s_rst = ($urandom_range(0, 199) == 0);
            if (!m_stalled) begin
                s_cpu_req  = ($urandom_range(0, 3) != 0);
                s_cpu_we   = $urandom_range(0, 1) == 1;
                s_cpu_addr = rnd_addr();
                s_cpu_din  = $urandom;
            end
            if (s_dbg_req) begin
                if (m_ack)
                    s_dbg_req = $urandom_range(0, 1) == 1;
            end else if ($urandom_range(0, 3) == 0) begin
                s_dbg_req  = 1'b1;
                s_dbg_we   = $urandom_range(0, 1) == 1;
                s_dbg_addr = rnd_addr();
                s_dbg_din  = $urandom;
            end
            step();
        end
        s_rst = 1'b0; s_cpu_req = 1'b0; s_dbg_req = 1'b0;
        step();
        @(negedge clk);
        #1;
        for (int i = 0; i < 16; i++)
            check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Two-master arbiter for the single data-memory port of the memory subsystem. It shares `dm_addr`/`dm_we`/`dm_din`/`dm_dout` between the CPU load/store path and a debug/loader master (program download, memory poke/peek). The CPU has priority. A starvation counter guarantees the debug master a slot, and the CPU is stalled for exactly the cycles the debug master owns the port. The block sits between the CPU and the MEM data port; the instruction port is untouched.

## Interface
Parameters:
- `MAX_WAIT`, default 4: maximum number of cycles a pending debug request may lose to the CPU. 0 gives the debug master absolute priority.
- `WAIT_W`, default 3: width of the wait counter. Must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_dm_req`  in  1  CPU accesses data memory this cycle (load or store).
- `cpu_dm_we`  in  1  CPU store strobe.
- `cpu_dm_addr`  in  32  CPU byte address.
- `cpu_dm_din`  in  32  CPU store data.
- `cpu_dm_dout`  out  32  load data to CPU; combinational pass of `dm_dout`.
- `cpu_stall`  out  1  CPU must freeze and hold its request.
- `dbg_req`  in  1  debug request; held until `dbg_ack`.
- `dbg_we`, `dbg_addr[31:0]`, `dbg_din[31:0]`  in  debug write strobe, address and data. These must be stable while `dbg_req` is high.
- `dbg_ack`  out  1  one-cycle pulse: the debug access has completed.
- `dbg_rdata`  out  32  read data, valid while `dbg_ack` is high and held until the next ack.
- `dm_addr`, `dm_din`  out  32  to the MEM data port.
- `dm_we`  out  1  to the MEM data port.
- `dm_dout`  in  32  from the MEM data port (combinational read).
- `stall_cnt`  out  16  see Configuration.

## Operation
- Memory model: combinational read, write on the rising edge when `dm_we` is high.
- Debug FSM:
  - IDLE: debug grant is possible.
  - RESP: the cycle in which `dbg_ack` is high. No debug grant is given in RESP; the next state is always IDLE. This one-cycle gap prevents a held `dbg_req` from being served twice.
- `dbg_grant` = `!rst` && state==IDLE && `dbg_req` && (`!cpu_dm_req` || `wait_cnt`==MAX_WAIT).
- Port mux:
  - When `dbg_grant` is high, `dm_addr`/`dm_din`/`dm_we` take the `dbg_*` values.
  - Otherwise they take the `cpu_dm_*` values, with `dm_we` = `cpu_dm_we` && `cpu_dm_req`.
  - `dm_we` is forced to 0 while `rst` is high.
- `cpu_stall` = `cpu_dm_req` && `dbg_grant`. A stalled store must not reach memory; the mux guarantees this.
- Wait counter (`WAIT_W` bits):
  - Clears on grant, and whenever `dbg_req` is low.
  - Increments when `dbg_req` is high in IDLE without a grant.
  - Saturates at MAX_WAIT.
- On the grant edge: `dbg_rdata` <= `dm_dout` (captured for reads and writes), `dbg_ack` <= 1, state <= RESP.
- Simultaneous `cpu_dm_req` and `dbg_req` with `wait_cnt` < MAX_WAIT: the CPU wins and `wait_cnt` increments.

## Timing
- Debug access latency:
  - Grant in cycle N, ack in N+1, earliest next grant N+2.
  - With the CPU continuously requesting, the worst case is grant at N+MAX_WAIT from request assertion at N.
- CPU access: zero added latency when not stalled; each debug grant costs at most one stall cycle.
- Reset values: state IDLE, `wait_cnt` 0, `dbg_ack` 0, `dbg_rdata` 0, `stall_cnt` 0. `cpu_stall` is 0 during reset.
- Reset mid-operation: a pending ack is discarded. The debug master re-issues its request after reset.

## Configuration
- `DM_ARB_STATS_EN` defined:
  - `stall_cnt` counts the cycles with `cpu_stall` high.
  - It saturates at 16'hFFFF and is cleared by `rst`.
- `DM_ARB_STATS_EN` undefined: `stall_cnt` is tied to 0 and no counter register exists.

## Test plan
- Reset: hold `rst` for 2 cycles while `dbg_req`=1 and `cpu_dm_req`=1/`cpu_dm_we`=1 → `dm_we`=0, `dbg_ack`=0, `cpu_stall`=0, `dbg_rdata`=0.
- Idle CPU, debug write then read: write addr 0x10 ← 0xDEADBEEF → ack one cycle after grant; a read of 0x10 returns `dbg_rdata`=0xDEADBEEF with `dbg_ack` pulsing exactly 1 cycle.
- Starvation, MAX_WAIT=4: `cpu_dm_req` held at 1 and `dbg_req` raised at cycle 0 → grant at cycle 4, `cpu_stall`=1 for that cycle only, ack at cycle 5.
- Held request: `dbg_req` kept high for 6 cycles with the CPU idle → grants in cycles 0, 2 and 4 only; acks in cycles 1, 3 and 5.
- Stalled store: CPU store to 0x20 ← 0x1 in the cycle the debug master is granted a read of 0x20 → the read sees the old value; the store lands the next cycle once the stall drops.
- `DM_ARB_STATS_EN`: the starvation scenario repeated 3 times → `stall_cnt`=3. Without the macro → `stall_cnt`=0.
